// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - execute-side, regfile-side and snoop signals of the writeback queue
interface regfile_write_queue_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  InValid;
    logic                  InReady;
    logic [4:0]            InRegister;
    logic [DATA_WIDTH-1:0] InData;
    logic                  DrainEn;
    logic [4:0]            WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [4:0]            ReadRegister1;
    logic [4:0]            ReadRegister2;
    logic                  BypassHit1;
    logic [DATA_WIDTH-1:0] BypassData1;
    logic                  BypassHit2;
    logic [DATA_WIDTH-1:0] BypassData2;
    logic [CW-1:0]         Count;
    logic                  Empty;

    modport master (
        output InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
        input  InReady, WriteRegister, WriteData, RegWrite,
        input  BypassHit1, BypassData1, BypassHit2, BypassData2, Count, Empty
    );

    modport slave (
        input  InValid, InRegister, InData, DrainEn, ReadRegister1, ReadRegister2,
        output InReady, WriteRegister, WriteData, RegWrite,
        output BypassHit1, BypassData1, BypassHit2, BypassData2, Count, Empty
    );
endinterface

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - writeback FIFO in front of the regfile write port with read snooping
// Optional macro REGFILE_WRITE_QUEUE_BYPASS_EN builds the forwarding comparators.
module regfile_write_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    regfile_write_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]            reg_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic full;
    logic empty;
    logic push_hs;
    logic accept;
    logic pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // no push-through when full, even if the head drains this cycle
    assign push_hs = bus.InValid && !full;
    assign accept  = push_hs && (bus.InRegister != 5'd0);
    assign pop     = bus.DrainEn && !empty;

    assign bus.InReady       = !full;
    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = empty ? 5'd0 : reg_q[rd_ptr];
    assign bus.WriteData     = empty ? '0 : data_q[rd_ptr];
    assign bus.Count         = count;
    assign bus.Empty         = empty;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // entry contents need no reset; validity is carried entirely by count
    always_ff @(posedge Clk) begin
        if (accept) begin
            reg_q[wr_ptr]  <= bus.InRegister;
            data_q[wr_ptr] <= bus.InData;
        end
    end

`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    // scan oldest to newest so the newest match wins; result is {hit, data}
    function automatic logic [DATA_WIDTH:0] snoop(input logic [4:0] ra);
        logic [DATA_WIDTH:0] res;
        logic [AW-1:0]       idx;
        res = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (ra != 5'd0) && (reg_q[idx] == ra))
                res = {1'b1, data_q[idx]};
        end
        return res;
    endfunction

    logic [DATA_WIDTH:0] snoop1;
    logic [DATA_WIDTH:0] snoop2;

    always_comb begin
        snoop1 = snoop(bus.ReadRegister1);
        snoop2 = snoop(bus.ReadRegister2);
    end

    assign bus.BypassHit1  = snoop1[DATA_WIDTH];
    assign bus.BypassData1 = snoop1[DATA_WIDTH-1:0];
    assign bus.BypassHit2  = snoop2[DATA_WIDTH];
    assign bus.BypassData2 = snoop2[DATA_WIDTH-1:0];
`else
    logic unused_read_regs;
    assign unused_read_regs = ^{bus.ReadRegister1, bus.ReadRegister2};

    assign bus.BypassHit1  = 1'b0;
    assign bus.BypassData1 = '0;
    assign bus.BypassHit2  = 1'b0;
    assign bus.BypassData2 = '0;
`endif
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed bench for regfile_write_queue
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic Clk;
    logic ResetN;
    int   total;
    int   passed;

    regfile_write_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.InValid    = 1'b1;
        bus.InRegister = r;
        bus.InData     = d;
        tick();
        bus.InValid    = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        ResetN = 1'b0;
        bus.InValid       = 1'b0;
        bus.InRegister    = 5'd0;
        bus.InData        = '0;
        bus.DrainEn       = 1'b0;
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;
        tick();
        tick();
        settle();
        chk("rst_count",   32'(bus.Count), 0);
        chk("rst_empty",   32'(bus.Empty), 1);
        chk("rst_inready", 32'(bus.InReady), 1);
        chk("rst_regwrite", 32'(bus.RegWrite), 0);
        chk("rst_wreg",    32'(bus.WriteRegister), 0);
        chk("rst_wdata",   bus.WriteData, 0);
        chk("rst_hit1",    32'(bus.BypassHit1), 0);
        chk("rst_hit2",    32'(bus.BypassHit2), 0);
        ResetN = 1'b1;

        // single push, drained the following cycle
        bus.DrainEn = 1'b1;
        push(5'd2, 32'd42);
        settle();
        chk("t1_regwrite", 32'(bus.RegWrite), 1);
        chk("t1_wreg",     32'(bus.WriteRegister), 2);
        chk("t1_wdata",    bus.WriteData, 42);
        tick();
        settle();
        chk("t1_empty",    32'(bus.Empty), 1);
        chk("t1_regwrite_off", 32'(bus.RegWrite), 0);

        // fill to DEPTH with drain held off
        bus.DrainEn = 1'b0;
        push(5'd3, 32'd20);
        push(5'd4, 32'd25);
        push(5'd5, 32'd30);
        push(5'd6, 32'd35);
        settle();
        chk("t2_count_full", 32'(bus.Count), 4);
        chk("t2_inready",    32'(bus.InReady), 0);
        chk("t2_regwrite_held", 32'(bus.RegWrite), 0);
        push(5'd7, 32'd40);
        settle();
        chk("t2_fifth_rejected", 32'(bus.Count), 4);
        bus.DrainEn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_drain_we",   32'(bus.RegWrite), 1);
            chk("t2_drain_reg",  32'(bus.WriteRegister), 32'(3 + k));
            chk("t2_drain_data", bus.WriteData, 32'(20 + 5 * k));
            tick();
        end
        settle();
        chk("t2_empty", 32'(bus.Empty), 1);

        // register 0 handshakes but is discarded
        bus.DrainEn = 1'b0;
        bus.InValid = 1'b1;
        bus.InRegister = 5'd0;
        bus.InData = 32'd99;
        settle();
        chk("t3_inready", 32'(bus.InReady), 1);
        tick();
        bus.InValid = 1'b0;
        bus.DrainEn = 1'b1;
        settle();
        chk("t3_count",    32'(bus.Count), 0);
        chk("t3_regwrite", 32'(bus.RegWrite), 0);

        // duplicate destination: newest pending value forwards
        bus.DrainEn = 1'b0;
        push(5'd17, 32'd11);
        push(5'd17, 32'd17);
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd17;
        settle();
        chk("t4_hit2",  32'(bus.BypassHit2), 32'(BYP));
        chk("t4_data2", bus.BypassData2, BYP ? 32'd17 : 32'd0);
        chk("t4_hit1_r0", 32'(bus.BypassHit1), 0);
        bus.ReadRegister1 = 5'd17;
        settle();
        chk("t4_hit1",  32'(bus.BypassHit1), 32'(BYP));
        chk("t4_data1", bus.BypassData1, BYP ? 32'd17 : 32'd0);
        bus.DrainEn = 1'b1;
        settle();
        chk("t4_first_wdata", bus.WriteData, 11);
        tick();
        settle();
        chk("t4_after_pop_data2", bus.BypassData2, BYP ? 32'd17 : 32'd0);
        chk("t4_second_wdata", bus.WriteData, 17);
        tick();
        settle();
        chk("t4_drained_hit2", 32'(bus.BypassHit2), 0);
        chk("t4_drained_empty", 32'(bus.Empty), 1);
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;

        // streaming: one push per cycle while draining, pointers wrap
        bus.DrainEn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus.InValid    = (k <= 8);
            bus.InRegister = 5'(k);
            bus.InData     = 32'(100 + 3 * k);
            settle();
            chk("t5_count", 32'(bus.Count), (k == 1) ? 32'd0 : 32'd1);
            if (k > 1) begin
                chk("t5_we",   32'(bus.RegWrite), 1);
                chk("t5_reg",  32'(bus.WriteRegister), 32'(k - 1));
                chk("t5_data", bus.WriteData, 32'(100 + 3 * (k - 1)));
            end
            tick();
        end
        bus.InValid = 1'b0;
        settle();
        chk("t5_empty", 32'(bus.Empty), 1);

        // asynchronous reset with three entries pending
        bus.DrainEn = 1'b0;
        push(5'd9, 32'd900);
        push(5'd10, 32'd1000);
        push(5'd11, 32'd1100);
        bus.ReadRegister1 = 5'd9;
        bus.DrainEn = 1'b1;
        settle();
        chk("t6_pre_count", 32'(bus.Count), 3);
        chk("t6_pre_hit1",  32'(bus.BypassHit1), 32'(BYP));
        chk("t6_pre_we",    32'(bus.RegWrite), 1);
        ResetN = 1'b0;
        #1;
        chk("t6_rst_we",    32'(bus.RegWrite), 0);
        chk("t6_rst_count", 32'(bus.Count), 0);
        chk("t6_rst_hit1",  32'(bus.BypassHit1), 0);
        tick();
        ResetN = 1'b1;
        settle();
        chk("t6_post_empty", 32'(bus.Empty), 1);
        chk("t6_post_we",    32'(bus.RegWrite), 0);
        tick();
        settle();
        chk("t6_post_wreg",  32'(bus.WriteRegister), 0);
        chk("t6_post_count", 32'(bus.Count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
